// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral endpoint: word width default,
// FSM encoding and clock-mode constants.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Only mode 0 is implemented; these select the sample/shift sclk edges.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and local-bus bundle of the SPI peripheral endpoint.
interface spi_slave_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall detection
// against a one-flop history of the synchronised level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchroniser chain and edge-history flop, reset to the idle pin level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 peripheral endpoint: oversampled pins, MSB-first shift, one-deep
// transmit holding buffer and a one-cycle receive strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk_in,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic w_unused_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_unused_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_sample_edge, w_shift_edge, w_consume;

  spi_state_e        r_state, w_state_nxt;
  logic              r_busy, w_busy_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_W-1:0] r_hold, w_hold_nxt;
  logic              r_tx_ready, w_tx_ready_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_underrun, w_underrun_nxt;
  logic              r_miso, w_miso_nxt;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk_in), .i_rst(rst), .i_pin(bus.sclk),
    .o_level(w_unused_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(clk_in), .i_rst(rst), .i_pin(bus.cs_n),
    .o_level(w_unused_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // Same depth as sclk so the mosi level lines up with the detected sample edge.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(clk_in), .i_rst(rst), .i_pin(bus.mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  assign w_sample_edge = (SPI_CPOL == SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_shift_edge  = (SPI_CPOL == SPI_CPHA) ? w_sclk_fall : w_sclk_rise;

  // Next-state, datapath and holding-buffer logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = r_busy;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_sh_nxt    = r_rx_sh;
    w_tx_sh_nxt    = r_tx_sh;
    w_hold_nxt     = r_hold;
    w_tx_ready_nxt = r_tx_ready;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_underrun_nxt = 1'b0;
    w_consume      = 1'b0;

    if (w_cs_rise) begin
      w_state_nxt   = ST_IDLE;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = '0;
      w_rx_sh_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            w_state_nxt   = ST_SHIFT;
            w_busy_nxt    = 1'b1;
            w_bit_cnt_nxt = '0;
            w_consume     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_sample_edge) begin
            w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], w_mosi};
            if (r_bit_cnt == CNT_LAST) begin
              w_bit_cnt_nxt  = '0;
              w_rx_data_nxt  = {r_rx_sh[DATA_W-2:0], w_mosi};
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end else if (w_shift_edge) begin
            if (r_bit_cnt == '0) begin
              w_consume = 1'b1;
            end else begin
              w_tx_sh_nxt = {r_tx_sh[DATA_W-2:0], 1'b0};
            end
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end

    if (w_consume) begin
      if (!r_tx_ready) begin
        w_tx_sh_nxt    = r_hold;
        w_tx_ready_nxt = 1'b1;
      end else begin
        w_tx_sh_nxt    = '0;
        w_underrun_nxt = 1'b1;
      end
    end else begin
      w_underrun_nxt = 1'b0;
    end

    // A load sees the pre-consumption buffer state, so it survives an underrun.
    if (bus.tx_load && r_tx_ready) begin
      w_hold_nxt     = bus.tx_data;
      w_tx_ready_nxt = 1'b0;
    end else begin
      w_hold_nxt = w_hold_nxt;
    end

    w_miso_nxt = w_busy_nxt ? w_tx_sh_nxt[DATA_W-1] : 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      r_hold     <= '0;
      r_tx_ready <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_hold     <= w_hold_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_underrun <= w_underrun_nxt;
      r_miso     <= w_miso_nxt;
    end
  end

  assign bus.miso        = r_miso;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_underrun;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master at clk_in/10 with hand-computed
// expected words, strobes and buffer states.
module tb_spi_slave;

  logic clk_in = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   rx_cnt = 0;
  int   unr_cnt = 0;
  int   long_cnt = 0;
  logic prev_rxv = 1'b0;
  logic prev_unr = 1'b0;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  // Strobe monitor: counts pulses and flags any strobe wider than one cycle.
  always @(negedge clk_in) begin
    if (bus.rx_valid === 1'b1) rx_cnt = rx_cnt + 1;
    if (bus.tx_underrun === 1'b1) unr_cnt = unr_cnt + 1;
    if ((bus.rx_valid && prev_rxv) || (bus.tx_underrun && prev_unr)) long_cnt = long_cnt + 1;
    prev_rxv = bus.rx_valid;
    prev_unr = bus.tx_underrun;
  end

  task automatic load_tx(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk_in);
    bus.tx_load = 1'b0;
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic cs_high();
    repeat (5) @(negedge clk_in);
    bus.cs_n = 1'b1;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic spi_word(input logic [7:0] mw, output logic [7:0] sw);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = mw[i];
      repeat (5) @(negedge clk_in);
      sw[i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (5) @(negedge clk_in);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    vectors++;
    if ({bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun, bus.busy} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got miso=%b rdy=%b rx=%h v=%b u=%b busy=%b", bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun, bus.busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_basic();
    logic [7:0] sw;
    int rx0, unr0;
    load_tx(8'hA5);
    vectors++;
    if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_after_load: got %b want 0", bus.tx_ready); end
    rx0 = rx_cnt; unr0 = unr_cnt;
    cs_low();
    vectors++;
    if ({bus.tx_ready, bus.busy} !== 2'b11) begin miscompares++; $display("FAIL basic_ready_busy: got %b want 11", {bus.tx_ready, bus.busy}); end
    vectors++;
    if (unr_cnt - unr0 !== 0) begin miscompares++; $display("FAIL basic_no_underrun: got %0d want 0", unr_cnt - unr0); end
    spi_word(8'h3C, sw);
    cs_high();
    vectors++;
    if (sw !== 8'hA5) begin miscompares++; $display("FAIL basic_miso_word: got %h want a5", sw); end
    vectors++;
    if (bus.rx_data !== 8'h3C) begin miscompares++; $display("FAIL basic_rx_data: got %h want 3c", bus.rx_data); end
    vectors++;
    if (rx_cnt - rx0 !== 1) begin miscompares++; $display("FAIL basic_rx_valid_count: got %0d want 1", rx_cnt - rx0); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sw1, sw2;
    int rx0;
    load_tx(8'h9A);
    rx0 = rx_cnt;
    cs_low();
    load_tx(8'h56);
    spi_word(8'h12, sw1);
    vectors++;
    if (bus.rx_data !== 8'h12 || rx_cnt - rx0 !== 1) begin
      miscompares++; $display("FAIL b2b_first_word: got rx=%h n=%0d want 12 n=1", bus.rx_data, rx_cnt - rx0);
    end
    spi_word(8'h34, sw2);
    cs_high();
    vectors++;
    if (bus.rx_data !== 8'h34 || rx_cnt - rx0 !== 2) begin
      miscompares++; $display("FAIL b2b_second_word: got rx=%h n=%0d want 34 n=2", bus.rx_data, rx_cnt - rx0);
    end
    vectors++;
    if ({sw1, sw2} !== {8'h9A, 8'h56}) begin miscompares++; $display("FAIL b2b_miso_words: got %h %h want 9a 56", sw1, sw2); end
  endtask

  task automatic test_underrun();
    logic [7:0] sw;
    int unr0;
    unr0 = unr_cnt;
    cs_low();
    vectors++;
    if (unr_cnt - unr0 !== 1) begin miscompares++; $display("FAIL underrun_pulse: got %0d want 1", unr_cnt - unr0); end
    spi_word(8'hFF, sw);
    cs_high();
    vectors++;
    if (sw !== 8'h00) begin miscompares++; $display("FAIL underrun_miso: got %h want 00", sw); end
    vectors++;
    if (bus.rx_data !== 8'hFF) begin miscompares++; $display("FAIL underrun_rx: got %h want ff", bus.rx_data); end
  endtask

  task automatic test_abort();
    logic [7:0] sw;
    int rx0;
    rx0 = rx_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) begin
      bus.mosi = 1'b0;
      repeat (5) @(negedge clk_in);
      bus.sclk = 1'b1;
      repeat (5) @(negedge clk_in);
      bus.sclk = 1'b0;
    end
    cs_high();
    vectors++;
    if (rx_cnt - rx0 !== 0 || bus.rx_data !== 8'hFF) begin
      miscompares++; $display("FAIL abort_no_word: got n=%0d rx=%h want n=0 rx=ff", rx_cnt - rx0, bus.rx_data);
    end
    vectors++;
    if ({bus.busy, bus.miso} !== 2'b00) begin miscompares++; $display("FAIL abort_idle: got busy/miso=%b want 00", {bus.busy, bus.miso}); end
    cs_low();
    spi_word(8'h81, sw);
    cs_high();
    vectors++;
    if (bus.rx_data !== 8'h81 || rx_cnt - rx0 !== 1) begin
      miscompares++; $display("FAIL abort_next_word: got rx=%h n=%0d want 81 n=1", bus.rx_data, rx_cnt - rx0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] sw;
    int unr0;
    cs_low();
    load_tx(8'h5A);
    vectors++;
    if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL rst_preload_ready: got %b want 0", bus.tx_ready); end
    bus.mosi = 1'b1;
    repeat (5) @(negedge clk_in);
    bus.sclk = 1'b1;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    vectors++;
    if ({bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun, bus.busy} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got miso=%b rdy=%b rx=%h v=%b u=%b busy=%b", bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun, bus.busy);
    end
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
    unr0 = unr_cnt;
    cs_low();
    vectors++;
    if (unr_cnt - unr0 !== 1) begin miscompares++; $display("FAIL rst_buffer_empty: got underruns=%0d want 1", unr_cnt - unr0); end
    spi_word(8'hC3, sw);
    cs_high();
    vectors++;
    if (bus.rx_data !== 8'hC3 || sw !== 8'h00) begin
      miscompares++; $display("FAIL rst_next_word: got rx=%h miso=%h want c3 00", bus.rx_data, sw);
    end
  endtask

  task automatic test_load_ignored();
    logic [7:0] sw;
    int unr0;
    load_tx(8'h11);
    bus.tx_data = 8'h77;
    bus.tx_load = 1'b1;
    repeat (4) @(negedge clk_in);
    bus.tx_load = 1'b0;
    vectors++;
    if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL ignore_ready_low: got %b want 0", bus.tx_ready); end
    cs_low();
    vectors++;
    if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL ignore_ready_after_cs: got %b want 1", bus.tx_ready); end
    spi_word(8'h00, sw);
    cs_high();
    vectors++;
    if (sw !== 8'h11) begin miscompares++; $display("FAIL ignore_miso_word: got %h want 11", sw); end
    unr0 = unr_cnt;
    cs_low();
    spi_word(8'h00, sw);
    cs_high();
    vectors++;
    if (sw !== 8'h00 || unr_cnt - unr0 !== 2) begin
      miscompares++; $display("FAIL ignore_not_captured: got miso=%h underruns=%0d want 00 2", sw, unr_cnt - unr0);
    end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    rst = 1'b1;
    @(negedge clk_in);
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_mid_reset();
    test_load_ignored();
    vectors++;
    if (long_cnt !== 0) begin miscompares++; $display("FAIL strobe_width: got %0d wide strobes want 0", long_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
